// File: rtl/vdp_pixel_pipe.sv
// Pixel stage behind the VDP timing generator: prefetches 4bpp bitmap words from VRAM
// through a small FIFO, maps each nibble through a 16x12 palette and drives the DAC pins.
module vdp_pixel_pipe #(
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dot_en,
    input  logic              line_start,
    input  logic              frame_start,
    input  logic              active,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        line_words,
    output logic              vram_rd,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [15:0]       vram_rdata,
    input  logic              pal_we,
    input  logic [3:0]        pal_index,
    input  logic [11:0]       pal_data,
    output logic [3:0]        r,
    output logic [3:0]        g,
    output logic [3:0]        b,
    output logic              hsync,
    output logic              vsync,
    output logic              underrun
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, FETCH} fetch_state_t;

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] line_addr_reg, line_addr_next;
    logic [ADDR_W-1:0] fetch_addr_reg;
    logic [7:0]        words_left_reg;
    logic              vram_rd_reg;
    logic [ADDR_W-1:0] vram_addr_reg;
    logic              ret_valid_reg;

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;

    logic [1:0]        nib_pos_reg;
    logic [11:0]       rgb_reg;
    logic              hsync_reg, vsync_reg, underrun_reg;
    logic [11:0]       pal_mem [16];

    logic [CW:0]       outstanding;
    logic              issue, push, pop, pixel_fire, have_word;
    logic [15:0]       cur_word;
    logic [3:0]        nibbles [4];
    logic [3:0]        pix_index;

    always_comb begin
        line_addr_next = line_addr_reg;
        if (frame_start)
            line_addr_next = base_addr;
        else if (line_start)
            line_addr_next = line_addr_reg + ADDR_W'(line_words);
    end

    // Words already queued plus both pipeline slots of the VRAM read must fit in the FIFO.
    assign outstanding = {1'b0, count_reg} + (CW+1)'(vram_rd_reg) + (CW+1)'(ret_valid_reg);
    assign issue       = (state_reg == FETCH) && (words_left_reg != 8'd0) &&
                         (outstanding < (CW+1)'(FIFO_DEPTH)) && !line_start;
    assign push        = ret_valid_reg && !line_start;

    assign pixel_fire  = dot_en && active;
    assign have_word   = (count_reg != '0);
    assign cur_word    = fifo_mem[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign nibbles[gi] = cur_word[15 - 4*gi -: 4];
        end
    endgenerate

    assign pix_index = have_word ? nibbles[nib_pos_reg] : 4'd0;
    assign pop       = pixel_fire && have_word && (nib_pos_reg == 2'd3) && !line_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            line_addr_reg  <= '0;
            fetch_addr_reg <= '0;
            words_left_reg <= '0;
            vram_rd_reg    <= 1'b0;
            vram_addr_reg  <= '0;
            ret_valid_reg  <= 1'b0;
        end else begin
            line_addr_reg <= line_addr_next;
            vram_rd_reg   <= issue;
            // A read still in flight across a line_start belongs to the old line.
            ret_valid_reg <= vram_rd_reg && !line_start;
            if (line_start) begin
                fetch_addr_reg <= line_addr_next;
                words_left_reg <= line_words;
                state_reg      <= (line_words != 8'd0) ? FETCH : IDLE;
            end else if (issue) begin
                vram_addr_reg  <= fetch_addr_reg;
                fetch_addr_reg <= fetch_addr_reg + ADDR_W'(1);
                words_left_reg <= words_left_reg - 8'd1;
                if (words_left_reg == 8'd1)
                    state_reg <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= vram_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (line_start) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (pal_we)
            pal_mem[pal_index] <= pal_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nib_pos_reg  <= 2'd0;
            rgb_reg      <= 12'h000;
            hsync_reg    <= 1'b0;
            vsync_reg    <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            hsync_reg <= hsync_in;
            vsync_reg <= vsync_in;
            if (line_start)
                nib_pos_reg <= 2'd0;
            else if (pixel_fire && have_word)
                nib_pos_reg <= nib_pos_reg + 2'd1;
            if (dot_en)
                rgb_reg <= active ? pal_mem[pix_index] : 12'h000;
            if (pixel_fire && !have_word)
                underrun_reg <= 1'b1;
        end
    end

    assign vram_rd   = vram_rd_reg;
    assign vram_addr = vram_addr_reg;
    assign r         = rgb_reg[11:8];
    assign g         = rgb_reg[7:4];
    assign b         = rgb_reg[3:0];
    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;
    assign underrun  = underrun_reg;

endmodule
